// File: rtl/full_adder_1b_pkg.sv
// Shared types for the full_adder_1b bit-slice cell.
// The result pair keeps carry ahead of sum, the same order as the cell's ports.
package full_adder_1b_pkg;

  typedef struct packed {
    logic carry;
    logic sum;
  } fa_result_t;

endpackage : full_adder_1b_pkg

// File: rtl/full_adder_1b_if.sv
// Operand/result bundle between the full_adder_1b register wrapper and its core.
// The master drives the operand bits. The slave returns sum/carry and gen/prop.
interface full_adder_1b_if;
  logic a;
  logic b;
  logic cin;
  logic carry;
  logic sum;
  logic gen;
  logic prop;

  modport master (output a, b, cin, input carry, sum, gen, prop);
  modport slave  (input a, b, cin, output carry, sum, gen, prop);
endinterface : full_adder_1b_if

// File: rtl/full_adder_1b_core.sv
// Pure combinational full-adder slice with generate/propagate terms for lookahead use.
// Plain operators are used so that X/Z on any input reaches the outputs unmasked.
module full_adder_1b_core (
  full_adder_1b_if.slave bus
);

  assign bus.gen   = bus.a & bus.b;
  assign bus.prop  = bus.a ^ bus.b;
  assign bus.sum   = bus.prop ^ bus.cin;
  assign bus.carry = bus.gen | (bus.cin & bus.prop);

endmodule : full_adder_1b_core

// File: rtl/full_adder_1b.sv
// 1-bit full adder with combinational outputs and a registered copy of carry/sum.
// Existing instantiations depend on the port order: the operands come first, then carry before sum.
module full_adder_1b
  import full_adder_1b_pkg::*;
(
  input  logic input_a,
  input  logic input_b,
  input  logic input_carry,
  output logic output_carry,
  output logic output_sum,
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic output_carry_q,
  output logic output_sum_q,
  output logic output_gen,
  output logic output_prop
);

  full_adder_1b_if core_bus ();

  assign core_bus.a   = input_a;
  assign core_bus.b   = input_b;
  assign core_bus.cin = input_carry;

  full_adder_1b_core u_core (
    .bus (core_bus.slave)
  );

  assign output_carry = core_bus.carry;
  assign output_sum   = core_bus.sum;
  assign output_gen   = core_bus.gen;
  assign output_prop  = core_bus.prop;

  fa_result_t result_q;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  // Reset is synchronous and takes priority over the capture enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '{carry: 1'b0, sum: 1'b0};
    end else if (en) begin
      result_q <= '{carry: core_bus.carry, sum: core_bus.sum};
    end
  end

  assign output_carry_q = result_q.carry;
  assign output_sum_q   = result_q.sum;

endmodule : full_adder_1b

// File: tb/tb_full_adder_1b.sv
// Self-checking bench for full_adder_1b: truth table, reset/capture/hold corners, random vs arithmetic model.
`timescale 1ns/1ps
module tb_full_adder_1b;

  logic clk;
  logic rst;
  logic en;
  logic carry_q;
  logic sum_q;

  full_adder_1b_if bus ();

  full_adder_1b dut (
    .input_a        (bus.a),
    .input_b        (bus.b),
    .input_carry    (bus.cin),
    .output_carry   (bus.carry),
    .output_sum     (bus.sum),
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .output_carry_q (carry_q),
    .output_sum_q   (sum_q),
    .output_gen     (bus.gen),
    .output_prop    (bus.prop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [1:0] actual, input logic [1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic       a;
    logic       b;
    logic       cin;
    logic       exp_carry;
    logic       exp_sum;
  } vec_t;

  vec_t vecs [8];

  task automatic drive(input logic a, input logic b, input logic cin);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
  endtask

  logic [1:0] model_q;
  logic [1:0] model_sum;

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    // Truth table written as constants, indexed by {Cin,B,A}
    vecs[0] = '{a:0, b:0, cin:0, exp_carry:0, exp_sum:0};
    vecs[1] = '{a:1, b:0, cin:0, exp_carry:0, exp_sum:1};
    vecs[2] = '{a:0, b:1, cin:0, exp_carry:0, exp_sum:1};
    vecs[3] = '{a:1, b:1, cin:0, exp_carry:1, exp_sum:0};
    vecs[4] = '{a:0, b:0, cin:1, exp_carry:0, exp_sum:1};
    vecs[5] = '{a:1, b:0, cin:1, exp_carry:1, exp_sum:0};
    vecs[6] = '{a:0, b:1, cin:1, exp_carry:1, exp_sum:0};
    vecs[7] = '{a:1, b:1, cin:1, exp_carry:1, exp_sum:1};

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      #100;
      check($sformatf("table_%0d {c,s}", i), {bus.carry, bus.sum},
            {vecs[i].exp_carry, vecs[i].exp_sum});
    end

    // Reset with all ones applied: q clears, combinational outputs stay 1/1
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1);
    en  = 1'b1;
    rst = 1'b1;
    #1 check("reset comb {c,s}", {bus.carry, bus.sum}, 2'b11);
    @(posedge clk); #1;
    check("reset q {c,s}", {carry_q, sum_q}, 2'b00);
    check("reset comb after edge", {bus.carry, bus.sum}, 2'b11);

    // Capture: 1+0+1 -> carry 1, sum 0 one edge later
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    #1 check("capture q before edge", {carry_q, sum_q}, 2'b00);
    @(posedge clk); #1;
    check("capture q", {carry_q, sum_q}, 2'b10);

    // Hold across three edges with en low and inputs cleared
    @(negedge clk);
    en = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #1 check("hold comb {c,s}", {bus.carry, bus.sum}, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold q edge %0d", k), {carry_q, sum_q}, 2'b10);
    end

    // Reset beats enable on the same edge
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0);
    en  = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset beats en q", {carry_q, sum_q}, 2'b00);
    check("reset beats en comb", {bus.carry, bus.sum}, 2'b10);

    // Generate / propagate
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    #1 check("gen/prop a1b1", {bus.gen, bus.prop}, 2'b10);
    drive(1'b1, 1'b0, 1'b0);
    #1 check("gen/prop a1b0", {bus.gen, bus.prop}, 2'b01);

    // Random traffic against an arithmetic model: {carry,sum} = a + b + cin
    model_q = 2'b00;
    for (int n = 0; n < 300; n++) begin
      logic ra, rb, rc;
      @(negedge clk);
      ra  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      rc  = 1'($urandom_range(0, 1));
      en  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 9) == 0);
      drive(ra, rb, rc);
      model_sum = 2'(int'(ra) + int'(rb) + int'(rc));
      #1;
      check("rand comb {c,s}", {bus.carry, bus.sum}, model_sum);
      check("rand {gen,prop}", {bus.gen, bus.prop},
            {(int'(ra) + int'(rb)) == 2, (int'(ra) + int'(rb)) == 1});
      if (rst)     model_q = 2'b00;
      else if (en) model_q = model_sum;
      @(posedge clk); #1;
      check("rand q {c,s}", {carry_q, sum_q}, model_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_full_adder_1b
